// File: rtl/tdm_demux2.sv
// Two-channel TDM deserializer: framed MSB-first serial stream -> channel A/B words with strobes.
// Define TDM_PARITY_EN to carry an even-parity bit after each slot's data bits.
module tdm_demux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] a_out,
  output logic             a_valid,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  output logic             sync_err,
  output logic             par_err,
  output logic             locked
);
`ifdef TDM_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int CW = $clog2(L);

  typedef enum logic [1:0] {IDLE, SLOT_A, SLOT_B} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [L-2:0]     sr, sr_n;
  logic [WIDTH-1:0] a_out_n, b_out_n;
  logic             a_valid_n, b_valid_n, sync_err_n, locked_n;
  logic [L-1:0]     full;
  logic [WIDTH-1:0] data;
  logic             last, ok;
`ifdef TDM_PARITY_EN
  logic             par_err_n;
`endif

  // full holds the slot's bits including the one being sampled now
  assign full = {sr, din};
  assign data = full[L-1 -: WIDTH];
  assign last = (cnt == CW'(L - 1));

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sr_n       = sr;
    a_out_n    = a_out;
    b_out_n    = b_out;
    a_valid_n  = 1'b0;
    b_valid_n  = 1'b0;
    sync_err_n = 1'b0;
    locked_n   = locked;
`ifdef TDM_PARITY_EN
    par_err_n  = 1'b0;
    ok         = ~^full;
`else
    ok         = 1'b1;
`endif
    if (en) begin
      if (state == IDLE) begin
        if (sync) begin
          locked_n = 1'b1;
          state_n  = SLOT_A;
          cnt_n    = CW'(1);
          sr_n     = '0;
          sr_n[0]  = din;
        end
      end else begin
        sr_n  = full[L-2:0];
        cnt_n = cnt + 1'b1;
        if (last) begin
          cnt_n   = '0;
          state_n = (state == SLOT_A) ? SLOT_B : SLOT_A;
          if (ok) begin
            if (state == SLOT_A) begin
              a_out_n   = data;
              a_valid_n = 1'b1;
            end else begin
              b_out_n   = data;
              b_valid_n = 1'b1;
            end
          end
`ifdef TDM_PARITY_EN
          else par_err_n = 1'b1;
`endif
        end
        // Off-boundary sync: drop the partial word (a just-finished slot B still delivers)
        if (sync && !(state == SLOT_A && cnt == '0)) begin
          sync_err_n = 1'b1;
          state_n    = SLOT_A;
          cnt_n      = CW'(1);
          sr_n       = '0;
          sr_n[0]    = din;
          if (!(state == SLOT_B && last)) begin
            a_out_n   = a_out;
            a_valid_n = 1'b0;
`ifdef TDM_PARITY_EN
            par_err_n = 1'b0;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      a_out    <= '0;
      b_out    <= '0;
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      sync_err <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sr       <= sr_n;
      a_out    <= a_out_n;
      b_out    <= b_out_n;
      a_valid  <= a_valid_n;
      b_valid  <= b_valid_n;
      sync_err <= sync_err_n;
      locked   <= locked_n;
    end
  end

`ifdef TDM_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) par_err <= 1'b0;
    else     par_err <= par_err_n;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux2.sv
// Directed bench for tdm_demux2 (WIDTH=8); parity cases run when TDM_PARITY_EN is defined.
module tb_tdm_demux2;
  localparam int W = 8;
`ifdef TDM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0, rst, en, din, sync;
  logic [W-1:0] a_out, b_out;
  logic a_valid, b_valid, sync_err, par_err, locked;

  int n_run = 0, n_fail = 0;
  int na = 0, nb = 0, nse = 0, npe = 0;

  tdm_demux2 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
    .a_out(a_out), .a_valid(a_valid), .b_out(b_out), .b_valid(b_valid),
    .sync_err(sync_err), .par_err(par_err), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sampled bit; outputs observed afterwards belong to the next cycle
  task automatic bit_step(input logic d, input logic s, input logic e);
    din = d; sync = s; en = e;
    @(posedge clk); #1;
    na  += int'(a_valid);
    nb  += int'(b_valid);
    nse += int'(sync_err);
    npe += int'(par_err);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic s0, input logic bad_par);
    for (int i = W - 1; i >= 0; i--) bit_step(w[i], (i == W - 1) && s0, 1'b1);
    if (PAR) bit_step((^w) ^ bad_par, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; din = 1'b0; sync = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    na = 0; nb = 0; nse = 0; npe = 0;
  endtask

  initial begin
    logic [W-1:0] w;
    // reset state and the basic frame
    do_reset();
    chk("rst_a_out", a_out, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_strobes", {a_valid, b_valid, sync_err, par_err}, 0);
    bit_step(1'b1, 1'b1, 1'b1);
    chk("locked_c1", locked, 1);
    w = 8'hA5;
    for (int i = W - 2; i >= 0; i--) bit_step(w[i], 1'b0, 1'b1);
    if (PAR) bit_step(^w, 1'b0, 1'b1);
    chk("f1_a_valid", a_valid, 1);
    chk("f1_a_out", a_out, 8'hA5);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("f1_b_valid", b_valid, 1);
    chk("f1_a_valid_low", a_valid, 0);
    chk("f1_b_out", b_out, 8'h3C);
    bit_step(1'b0, 1'b0, 1'b0);
    chk("f1_strobe_width", {a_valid, b_valid}, 0);

    // bits before any sync are discarded
    do_reset();
    for (int i = 0; i < 5; i++) bit_step(i[0], 1'b0, 1'b1);
    chk("pre_strobes", na + nb + nse, 0);
    chk("pre_locked", locked, 0);
    send_word(8'h12, 1'b1, 1'b0);
    chk("pre_a_out", a_out, 8'h12);
    send_word(8'h34, 1'b0, 1'b0);
    chk("pre_b_out", b_out, 8'h34);
    chk("pre_counts", {na[7:0], nb[7:0]}, 16'h0101);

    // flywheel: second frame without sync
    do_reset();
    send_word(8'h81, 1'b1, 1'b0);
    send_word(8'h7E, 1'b0, 1'b0);
    send_word(8'hC9, 1'b0, 1'b0);
    chk("fw_a2", a_out, 8'hC9);
    chk("fw_a2_valid", a_valid, 1);
    send_word(8'h36, 1'b0, 1'b0);
    chk("fw_b2", b_out, 8'h36);
    chk("fw_no_serr", nse, 0);
    chk("fw_counts", {na[7:0], nb[7:0]}, 16'h0202);

    // sync at cycle 3 of slot A: resync, partial word dropped
    do_reset();
    for (int i = 0; i < 3; i++) bit_step(1'b1, i == 0, 1'b1);
    w = 8'h5A;
    bit_step(w[W-1], 1'b1, 1'b1);
    chk("rs_sync_err", sync_err, 1);
    chk("rs_no_a_valid", a_valid, 0);
    for (int i = W - 2; i >= 0; i--) bit_step(w[i], 1'b0, 1'b1);
    if (PAR) bit_step(^w, 1'b0, 1'b1);
    chk("rs_a_valid", a_valid, 1);
    chk("rs_a_out", a_out, 8'h5A);
    chk("rs_counts", {na[7:0], nse[7:0]}, 16'h0101);

    // en low for 5 cycles mid slot B; sync/din toggling during the gap must be ignored
    do_reset();
    send_word(8'hC3, 1'b1, 1'b0);
    w = 8'h96;
    for (int i = W - 1; i >= 4; i--) bit_step(w[i], 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) bit_step(i[0], 1'b1, 1'b0);
    chk("en_no_b", nb, 0);
    chk("en_no_serr", nse, 0);
    for (int i = 3; i >= 0; i--) bit_step(w[i], 1'b0, 1'b1);
    if (PAR) bit_step(^w, 1'b0, 1'b1);
    chk("en_b_valid", b_valid, 1);
    chk("en_b_out", b_out, 8'h96);

    // rst mid-slot clears everything and drops lock
    send_word(8'hF0, 1'b1, 1'b0);
    bit_step(1'b1, 1'b0, 1'b1);
    bit_step(1'b0, 1'b0, 1'b1);
    do_reset();
    chk("mr_outs", {a_out, b_out}, 0);
    chk("mr_locked", locked, 0);
    for (int i = 0; i < 2 * W; i++) bit_step(1'b1, 1'b0, 1'b1);
    chk("mr_no_relock", {locked, na[7:0] | nb[7:0]}, 0);

`ifdef TDM_PARITY_EN
    do_reset();
    send_word(8'hA5, 1'b1, 1'b0);
    chk("p_a_valid", a_valid, 1);
    chk("p_a_out", a_out, 8'hA5);
    send_word(8'h3C, 1'b0, 1'b1);
    chk("p_par_err", par_err, 1);
    chk("p_no_b_valid", b_valid, 0);
    chk("p_b_out_kept", b_out, 0);
    send_word(8'h11, 1'b1, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("p_b_good", b_out, 8'h3C);
    send_word(8'h22, 1'b1, 1'b0);
    send_word(8'h55, 1'b0, 1'b1);
    chk("p_b_kept2", b_out, 8'h3C);
    chk("p_counts", {npe[7:0], nb[7:0]}, 16'h0201);
`else
    chk("np_par_zero", npe, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/tdm_demux2.md
# tdm_demux2

Two-channel time-division demultiplexer: the receive end of the serial link built from a 2:1 selector toggling between channels A and B. Deserializes a framed 1-bit stream, MSB first, into two WIDTH-bit words, one per slot, each with a single-cycle valid strobe. It sits between the serial line input and the per-channel consumer logic.

## Interface
- `WIDTH`, default 8: bits per channel word; legal range 2..16.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  sample enable; when low, `din` and `sync` are ignored and all state holds.
- `din`  input  1  serial data bit.
- `sync`  input  1  frame marker; high together with the first bit of slot A.
- `a_out`  output  WIDTH  last completed channel A word.
- `a_valid`  output  1  one-cycle strobe: `a_out` updated.
- `b_out`  output  WIDTH  last completed channel B word.
- `b_valid`  output  1  one-cycle strobe: `b_out` updated.
- `sync_err`  output  1  one-cycle strobe: `sync` seen off a frame boundary.
- `par_err`  output  1  one-cycle strobe: parity mismatch; constant 0 when parity is compiled out.
- `locked`  output  1  high once the first `sync` has been accepted.

## Operation
- States: IDLE (unlocked), SLOT_A, SLOT_B. Bit counter `cnt` counts 0..L-1, where L = WIDTH, or WIDTH+1 with parity.
- Reset: state IDLE, `cnt` 0, shift register 0; `a_out`, `b_out` = 0; `a_valid`, `b_valid`, `sync_err`, `par_err`, `locked` = 0.
- IDLE: a sampled bit with `sync`=0 is discarded. A sampled bit with `sync`=1 is taken as bit 0 of slot A: `locked`←1, state SLOT_A, `cnt`←1.
- SLOT_A and SLOT_B: each sampled bit is shifted in MSB first and `cnt` increments. On the L-th bit:
  - the word is transferred to `a_out` or `b_out`;
  - the matching valid strobe is raised;
  - `cnt`←0 and the state moves to the other slot.
- After SLOT_B the block returns to SLOT_A automatically (flywheel). `sync` is expected, not required, on the first bit of slot A.
- `sync`=1 on any sampled bit other than the first bit of slot A:
  - `sync_err` pulses;
  - the partial word is discarded and no valid strobe is raised for it;
  - that bit becomes bit 0 of slot A (resynchronise).
- `sync`=1 on the last bit of slot B: the same resync rule applies. Slot B completes first (`b_valid` fires), then `sync_err` fires and the bit is treated as the first bit of slot A.
- `en`=0: the counter, state, and shift register all hold. Strobes are still deasserted in the following cycle.
- Outputs `a_out` and `b_out` hold their values between updates and are never cleared except by `rst`.

## Timing
- Cycle 0 is the first sampled bit of slot A, with `sync`=1 and `en` high throughout.
  - `a_valid`=1 and the new `a_out` are visible in cycle L.
  - `b_valid`=1 and the new `b_out` are visible in cycle 2L.
  - The next frame's `sync` is expected in cycle 2L.
- Latency: 1 clock from sampling the last bit of a slot to its strobe. All outputs are registered.
- Strobes are exactly one cycle wide. `a_valid` and `b_valid` are never high together.
- `rst` has priority over every other input, including mid-slot. The partial word is dropped, and the block requires a new `sync` to lock.

## Configuration
- `TDM_PARITY_EN` defined:
  - each slot carries WIDTH data bits followed by one even-parity bit (XOR over data and parity equals 0);
  - L = WIDTH+1;
  - on mismatch, `par_err` pulses in the cycle the valid strobe would have fired, the valid strobe is suppressed, and the output register keeps its old value.
- `TDM_PARITY_EN` undefined:
  - L = WIDTH;
  - no parity logic is generated;
  - `par_err` is tied to 0.

## Test plan
- Reset, WIDTH=8, no parity; frame A=0xA5, B=0x3C with `sync` at cycle 0 -> `a_out`=0xA5 with `a_valid` in cycle 8; `b_out`=0x3C with `b_valid` in cycle 16; `locked`=1 from cycle 1.
- Bits streamed before any `sync` -> no strobes and `locked`=0; the first `sync` then starts a correct A/B sequence.
- Two frames, the second sent without `sync` -> flywheel decodes A2 and B2 correctly, with no `sync_err`.
- `sync` asserted at cycle 3 of slot A -> `sync_err` pulse in cycle 4; no `a_valid` for the partial word; the word starting at cycle 3 decodes as channel A.
- `en` low for 5 cycles mid-slot B -> `b_valid` delayed by exactly 5 cycles and `b_out` still correct; `rst` pulsed mid-slot -> all outputs return to 0 and `locked`=0.
- `TDM_PARITY_EN`, A=0xA5 with parity 0 -> `a_valid` in cycle 9; B=0x3C with a wrong parity bit -> `par_err` in cycle 18, no `b_valid`, `b_out` unchanged.
